hazard_ctrl: RTL and testbench

Parametrised hazard and stall controller for the five-stage pipeline. It handles the same load-use and ID-stage branch hazards as the existing combinational stall logic. It adds a scoreboard for the multi-cycle multiply/divide unit, a data-memory wait handshake that freezes the pipeline, and a branch-redirect flush. It also keeps registered stall-cause and stall-cycle performance state. It sits beside the datapath and drives the stall and flush enables of the F/D, D/E, E/M and M/W pipeline registers.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/md_busy_counter.sv | 38 +++
 rtl/hazard_ctrl.sv | 80 ++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared stall-cause and register-source encodings for the hazard unit
package hazard_pkg;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_LOAD   = 3'd1,
        CAUSE_BRANCH = 3'd2,
        CAUSE_MD     = 3'd3,
        CAUSE_MEM    = 3'd4
    } stall_cause_e;

    // Write-back source select used by the decode logic
    typedef enum logic [1:0] {
        REG_SRC_ALU  = 2'd0,
        REG_SRC_MEM  = 2'd1,
        REG_SRC_PC8  = 2'd2,
        REG_SRC_HILO = 2'd3
    } reg_src_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 32
);
    logic [REG_ADDR_W-1:0]     rsD, rtD;
    logic                      branchD, md_startD, md_readD, pc_redirectD;
    logic [REG_ADDR_W-1:0]     writeRegAddrE, writeRegAddrM;
    logic                      Regfile_weE, Regfile_weM;
    logic                      loadE, loadM, md_startE;
    logic                      mem_reqM, dmem_ready;
    logic                      stallF, stallD, stallE, stallM;
    logic                      flushD, flushE, flushW;
    logic                      md_busy;
    hazard_pkg::stall_cause_e  stall_cause;
    logic [PERF_W-1:0]         stall_cycles;

    modport master (
        output rsD, rtD, branchD, md_startD, md_readD, pc_redirectD,
               writeRegAddrE, writeRegAddrM, Regfile_weE, Regfile_weM,
               loadE, loadM, md_startE, mem_reqM, dmem_ready,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               md_busy, stall_cause, stall_cycles
    );

    modport slave (
        input  rsD, rtD, branchD, md_startD, md_readD, pc_redirectD,
               writeRegAddrE, writeRegAddrM, Regfile_weE, Regfile_weM,
               loadE, loadM, md_startE, mem_reqM, dmem_ready,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               md_busy, stall_cause, stall_cycles
    );
endinterface

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - mult/div busy scoreboard counter
module md_busy_counter #(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic hold,
    output logic busy
);
    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;

    // A held issue does not load; the E instruction re-issues once the hold clears
    always_comb begin
        count_d = count_q;
        if (start && !hold) begin
            count_d = CNT_W'(MD_LATENCY);
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with md scoreboard and stall statistics
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 4,
    parameter int PERF_W     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    logic lw_hz, br_hz, md_hz, mem_hz, md_busy;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    stall_cause_e      stall_cause_q, stall_cause_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    function automatic logic src_match(input logic [REG_ADDR_W-1:0] wr,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rt);
        return (wr != ZERO_REG) && ((wr == rs) || (wr == rt));
    endfunction

    md_busy_counter #(.MD_LATENCY(MD_LATENCY)) u_md_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (hz.md_startE),
        .hold  (mem_hz),
        .busy  (md_busy)
    );

    always_comb begin
        mem_hz = hz.mem_reqM && !hz.dmem_ready;
        lw_hz  = hz.loadE && hz.Regfile_weE && src_match(hz.writeRegAddrE, hz.rsD, hz.rtD);
        br_hz  = hz.branchD &&
                 ((hz.Regfile_weE && src_match(hz.writeRegAddrE, hz.rsD, hz.rtD)) ||
                  (hz.loadM && hz.Regfile_weM && src_match(hz.writeRegAddrM, hz.rsD, hz.rtD)));
        md_hz  = (hz.md_startD || hz.md_readD) && (md_busy || hz.md_startE);
    end

    // Memory wait freezes everything; data hazards bubble E; redirect squashes D
    always_comb begin
        stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
        flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
        stall_cause_d = CAUSE_NONE;
        if (mem_hz) begin
            {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
            stall_cause_d = CAUSE_MEM;
        end else if (lw_hz || br_hz || md_hz) begin
            {stall_f, stall_d, flush_e} = 3'b111;
            stall_cause_d = lw_hz ? CAUSE_LOAD : (br_hz ? CAUSE_BRANCH : CAUSE_MD);
        end else if (hz.pc_redirectD) begin
            flush_d = 1'b1;
        end
        stall_cycles_d = stall_cycles_q + PERF_W'(stall_f);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cause_q  <= CAUSE_NONE;
            stall_cycles_q <= '0;
        end else begin
            stall_cause_q  <= stall_cause_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.stallF       = stall_f;
    assign hz.stallD       = stall_d;
    assign hz.stallE       = stall_e;
    assign hz.stallM       = stall_m;
    assign hz.flushD       = flush_d;
    assign hz.flushE       = flush_e;
    assign hz.flushW       = flush_w;
    assign hz.md_busy      = md_busy;
    assign hz.stall_cause  = stall_cause_q;
    assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(5), .PERF_W(32)) hif ();

    hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(4), .PERF_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    // flags = {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       branch, mds_d, mdr_d, redir;
        logic [4:0] wr_e;
        logic       we_e, load_e;
        logic [4:0] wr_m;
        logic       we_m, load_m, mds_e, mem_req, ready;
        logic [6:0] flags;
        logic [2:0] cause;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    vec_t e;

    function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt,
                                logic branch, logic mds_d, logic mdr_d, logic redir,
                                logic [4:0] wr_e, logic we_e, logic load_e,
                                logic [4:0] wr_m, logic we_m, logic load_m,
                                logic mds_e, logic mem_req, logic ready,
                                logic [6:0] flags, logic [2:0] cause);
        vec_t v;
        v.name = name; v.rs = rs; v.rt = rt; v.branch = branch; v.mds_d = mds_d;
        v.mdr_d = mdr_d; v.redir = redir; v.wr_e = wr_e; v.we_e = we_e; v.load_e = load_e;
        v.wr_m = wr_m; v.we_m = we_m; v.load_m = load_m; v.mds_e = mds_e;
        v.mem_req = mem_req; v.ready = ready; v.flags = flags; v.cause = cause;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        hif.rsD = v.rs; hif.rtD = v.rt; hif.branchD = v.branch;
        hif.md_startD = v.mds_d; hif.md_readD = v.mdr_d; hif.pc_redirectD = v.redir;
        hif.writeRegAddrE = v.wr_e; hif.Regfile_weE = v.we_e; hif.loadE = v.load_e;
        hif.writeRegAddrM = v.wr_m; hif.Regfile_weM = v.we_m; hif.loadM = v.load_m;
        hif.md_startE = v.mds_e; hif.mem_reqM = v.mem_req; hif.dmem_ready = v.ready;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] flags_now();
        return {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.flushD, hif.flushE, hif.flushW};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    vec_t idle_v;

    initial begin
        idle_v = mk("idle", 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 7'b0000000, 3'd0);
        drive(idle_v);
        #12;
        check("reset_md_busy", 32'(hif.md_busy), 32'd0);
        check("reset_cause", 32'(hif.stall_cause), 32'd0);
        check("reset_cycles", hif.stall_cycles, 32'd0);
        rst_n = 1'b1;

        vecs.push_back(idle_v);
        vecs.push_back(mk("load_rs",      8,3, 0,0,0,0, 8,1,1, 0,0,0, 0,0,0, 7'b1100010, 3'd1));
        vecs.push_back(mk("load_rt",      3,8, 0,0,0,0, 8,1,1, 0,0,0, 0,0,0, 7'b1100010, 3'd1));
        vecs.push_back(mk("load_r0",      0,0, 0,0,0,0, 0,1,1, 0,0,0, 0,0,0, 7'b0000000, 3'd0));
        vecs.push_back(mk("load_nowe",    8,0, 0,0,0,0, 8,0,1, 0,0,0, 0,0,0, 7'b0000000, 3'd0));
        vecs.push_back(mk("br_loadM",     2,9, 1,0,0,0, 0,0,0, 9,1,1, 0,0,0, 7'b1100010, 3'd2));
        vecs.push_back(mk("br_loadM_r0",  2,0, 1,0,0,0, 0,0,0, 0,1,1, 0,0,0, 7'b0000000, 3'd0));
        vecs.push_back(mk("br_aluE",      5,1, 1,0,0,0, 5,1,0, 0,0,0, 0,0,0, 7'b1100010, 3'd2));
        vecs.push_back(mk("br_aluM",      5,1, 1,0,0,0, 0,0,0, 5,1,0, 0,0,0, 7'b0000000, 3'd0));
        vecs.push_back(mk("nobr_loadM",   9,1, 0,0,0,0, 0,0,0, 9,1,1, 0,0,0, 7'b0000000, 3'd0));
        vecs.push_back(mk("mdread_issE",  0,0, 0,0,1,0, 0,0,0, 0,0,0, 1,0,0, 7'b1100010, 3'd3));
        vecs.push_back(mk("mdstart_issE", 0,0, 0,1,0,0, 0,0,0, 0,0,0, 1,0,0, 7'b1100010, 3'd3));
        vecs.push_back(mk("redirect",     0,0, 0,0,0,1, 0,0,0, 0,0,0, 0,0,0, 7'b0000100, 3'd0));
        vecs.push_back(mk("lw_redirect",  8,0, 0,0,0,1, 8,1,1, 0,0,0, 0,0,0, 7'b1100010, 3'd1));
        vecs.push_back(mk("mem_wait",     0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,1,0, 7'b1111001, 3'd4));
        vecs.push_back(mk("mem_ready",    0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,1,1, 7'b0000000, 3'd0));
        vecs.push_back(mk("mem_lw_redir", 8,0, 0,0,0,1, 8,1,1, 0,0,0, 0,1,0, 7'b1111001, 3'd4));
        vecs.push_back(mk("lw_and_br",    7,0, 1,0,0,0, 7,1,1, 0,0,0, 0,0,0, 7'b1100010, 3'd1));
        vecs.push_back(mk("br_and_md",    1,6, 1,0,1,0, 6,1,0, 0,0,0, 1,0,0, 7'b1100010, 3'd2));
        vecs.push_back(mk("mem_and_md",   0,0, 0,0,1,0, 0,0,0, 0,0,0, 1,1,0, 7'b1111001, 3'd4));

        foreach (vecs[i]) begin
            do_reset();
            @(posedge clk); #1;
            drive(vecs[i]);
            sb_q.push_back(vecs[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            check({e.name, "_flags"}, 32'(flags_now()), 32'(e.flags));
            @(posedge clk); #1;
            drive(idle_v);
            @(negedge clk);
            check({e.name, "_cause"}, 32'(hif.stall_cause), 32'(e.cause));
        end

        // mult/div scoreboard window: issue at cycle 0, mfhi held in D
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            drive(mk("md_seq", 0,0, 0,0,1,0, 0,0,0, 0,0,0, (c == 0), 0,0,
                     (c <= 4) ? 7'b1100010 : 7'b0000000, {2'b00, (c >= 1 && c <= 4)}));
            sb_q.push_back(mk("md_seq", 0,0, 0,0,1,0, 0,0,0, 0,0,0, (c == 0), 0,0,
                     (c <= 4) ? 7'b1100010 : 7'b0000000, {2'b00, (c >= 1 && c <= 4)}));
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("md_stallD_c%0d", c), 32'(hif.stallD), 32'(e.flags[5]));
            check($sformatf("md_busy_c%0d", c), 32'(hif.md_busy), 32'(e.cause[0]));
        end

        // memory wait with load-use and redirect pending, three cycles
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            drive(vecs[16]);
            @(negedge clk);
            check($sformatf("memwait_flags_c%0d", c), 32'(flags_now()), 32'h79);
        end
        @(posedge clk); #1;
        drive(idle_v);
        @(negedge clk);
        check("memwait_cycles", hif.stall_cycles, 32'd3);
        check("memwait_cause", 32'(hif.stall_cause), 32'd4);
        @(posedge clk); #1;
        @(negedge clk);
        check("memwait_cause_clear", 32'(hif.stall_cause), 32'd0);
        check("memwait_cycles_hold", hif.stall_cycles, 32'd3);

        // md issue held by a memory wait must not start the busy window
        do_reset();
        @(posedge clk); #1;
        drive(mk("hold_iss", 0,0, 0,0,0,0, 0,0,0, 0,0,0, 1,1,0, 7'b0, 3'd0));
        @(negedge clk);
        check("held_issue_flags", 32'(flags_now()), 32'h79);
        @(posedge clk); #1;
        drive(mk("reiss", 0,0, 0,0,0,0, 0,0,0, 0,0,0, 1,1,1, 7'b0, 3'd0));
        @(negedge clk);
        check("held_issue_busy", 32'(hif.md_busy), 32'd0);
        @(posedge clk); #1;
        drive(idle_v);
        @(negedge clk);
        check("reissue_busy", 32'(hif.md_busy), 32'd1);

        // asynchronous reset while the counter sits at 2
        do_reset();
        @(posedge clk); #1;
        drive(mk("iss", 0,0, 0,0,1,0, 0,0,0, 0,0,0, 1,0,0, 7'b0, 3'd0));
        @(posedge clk); #1;
        drive(idle_v);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_reset_busy", 32'(hif.md_busy), 32'd1);
        check("pre_reset_cycles", hif.stall_cycles, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(hif.md_busy), 32'd0);
        check("async_reset_cycles", hif.stall_cycles, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(mk("rd", 0,0, 0,0,1,0, 0,0,0, 0,0,0, 0,0,0, 7'b0, 3'd0));
        @(negedge clk);
        check("post_reset_stallD", 32'(hif.stallD), 32'd0);
        check("post_reset_busy", 32'(hif.md_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
